alu_src_stage: RTL and testbench
================================

# alu_src_stage

Parametrised ALU-operand stage between decode and execute. Selects ALU source A (rs1 / pc / imm / zero) and source B (rs2 / imm / 4 / zero) and resolves register operands against up to `NUM_BYPASS` forwarding sources. Stalls on load-use hazards and registers the result into the ID/EX pipeline register behind a valid/ready handshake with flush. It supersedes the stand-alone combinational source-A multiplexer.

## Interface
- `XLEN`, 32, datapath width
- `NUM_BYPASS`, 2, forwarding sources; index 0 is youngest (EX), highest index oldest (WB)
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset; synchronous, active-low
- `in_valid`  in  1  decode presents an operand request
- `in_ready`  out  1  stage accepts the request this cycle
- `pc`, `rs1_data`, `rs2_data`, `imm`  in  XLEN each  raw operands from decode/regfile
- `rs1_addr`, `rs2_addr`  in  5 each  source register numbers
- `sel_a`  in  `SEL_SRC_A_WIDTH` (2)  source-A select
- `sel_b`  in  `SEL_SRC_B_WIDTH` (2)  source-B select
- `byp_valid`  in  NUM_BYPASS  source i holds a live destination write
- `byp_pending`  in  NUM_BYPASS  source i's data is not yet available (load in flight)
- `byp_rd`  in  5*NUM_BYPASS  destination register of source i, packed, i at [5i+4:5i]
- `byp_data`  in  XLEN*NUM_BYPASS  result of source i, packed
- `flush`  in  1  kill the held and incoming operation
- `out_valid`  out  1  operands valid to execute
- `out_ready`  in  1  execute accepts
- `alu_src_a`, `alu_src_b`  out  XLEN each  registered operands
- `store_data`  out  XLEN  registered forwarded rs2 value, independent of `sel_b`

## Operation
- Select encodings (package constants): A: 0 = RS1, 1 = PC, 2 = IMM, 3 = ZERO. B: 0 = RS2, 1 = IMM, 2 = CONST4 (value 4), 3 = ZERO.
- Forwarding per register operand: lowest index i with `byp_valid[i]` and `byp_rd[i] == addr` wins. Result is `byp_data[i]`, else regfile data. `addr == 0` never forwards; it yields regfile data unchanged.
- Hazard: the winning source has `byp_pending[i] = 1`, and the operand is needed. rs1 is needed only when `sel_a == RS1`. rs2 is needed always, because `store_data` consumes it.
- `in_ready = (!out_valid || out_ready) && !hazard`. A hazard holds `in_ready` low; nothing is captured.
- Capture when `in_valid && in_ready`: load `alu_src_a`, `alu_src_b`, `store_data`; set `out_valid`.
- Drain when `out_valid && out_ready` with no capture: clear `out_valid`.
- Data registers hold their value when not capturing.
- Operand arithmetic is pure selection. CONST4 is zero-extended to XLEN. No sign handling; `imm` arrives already extended.

## Timing
- Reset (`rst_n` low at edge): `out_valid = 0`, `alu_src_a = alu_src_b = store_data = 0`. Applies mid-transfer and discards held data.
- Latency: 1 cycle, from accepted input to `out_valid`.
- Throughput: 1 per cycle while `out_ready` is high. Back-to-back capture and drain in the same cycle is allowed.
- `in_ready` is combinational from `out_valid`, `out_ready` and the hazard inputs.
- Forwarded data is sampled at the capture edge.
- `flush` is synchronous and takes priority over capture and drain: next cycle `out_valid = 0`. Data registers are unchanged. `in_ready` is unaffected.
- Multiple matching sources: youngest (lowest index) wins, even if it is pending. In that case the stage stalls and does not fall through to an older source.
- Output stable under backpressure: while `out_valid && !out_ready`, all outputs hold.

## Configuration
- `ALU_SRC_BYPASS_EN` defined: forwarding and hazard logic as above.
- Not defined: `byp_*` ports remain but are ignored. Operands come straight from `rs1_data`/`rs2_data`. `hazard` is tied to 0, so `in_ready = !out_valid || out_ready`.

## Structure
- Package `alu_src_pkg`: `SEL_SRC_A_WIDTH`, `SEL_SRC_B_WIDTH`, the A/B select enum constants, `CONST4`.
- Sub-module `bypass_select`, instantiated twice (rs1, rs2).
  - Inputs: addr, regfile data, all `byp_*`.
  - Outputs: forwarded value, `hit_pending`.
- Top level holds the two muxes, hazard combine, handshake and pipeline register.

## Test plan
- Mux sweep: `pc = 0x20`, `rs1 = 0xA`, `rs2 = 0x5`, `imm = 0x4`, no bypass.
  - sel_a 0..3 -> `alu_src_a` = 0xA, 0x20, 0x4, 0x0.
  - sel_b 0..3 -> `alu_src_b` = 0x5, 0x4, 0x4, 0x0.
  - Each appears one cycle after acceptance.
- Forward priority: `rs1_addr = 3`, `byp_rd[0] = byp_rd[1] = 3`, `byp_data = {0x111, 0x222}` (source 0 = 0x222), both valid -> `alu_src_a = 0x222`. Same with `rs1_addr = 0` -> `rs1_data`.
- Load-use stall: `byp_pending[0] = 1` matching rs2 for 3 cycles -> `in_ready = 0` for 3 cycles. Capture occurs on the cycle pending drops, with the new `byp_data`.
- Backpressure: `out_ready = 0` for 4 cycles after a capture -> outputs constant, `in_ready = 0`. Release -> drain and new capture in the same cycle.
- Flush with `in_valid` and `out_valid` both high -> next cycle `out_valid = 0`.
- Reset mid-stream: `rst_n = 0` for 1 edge -> all outputs 0, then normal operation.
- Build without `ALU_SRC_BYPASS_EN`: a matching pending bypass causes neither a stall nor a forward.

Source files
------------

// File: rtl/alu_src_pkg.sv
// Shared select encodings and constants for the ALU operand stage.
package alu_src_pkg;

  localparam int SEL_SRC_A_WIDTH = 2;
  localparam int SEL_SRC_B_WIDTH = 2;

  typedef enum logic [SEL_SRC_A_WIDTH-1:0] {
    SEL_A_RS1  = 2'd0,
    SEL_A_PC   = 2'd1,
    SEL_A_IMM  = 2'd2,
    SEL_A_ZERO = 2'd3
  } sel_a_e;

  typedef enum logic [SEL_SRC_B_WIDTH-1:0] {
    SEL_B_RS2    = 2'd0,
    SEL_B_IMM    = 2'd1,
    SEL_B_CONST4 = 2'd2,
    SEL_B_ZERO   = 2'd3
  } sel_b_e;

  localparam logic [2:0] CONST4 = 3'd4;

endpackage

// File: rtl/alu_src_stage_bypass.sv
// Resolves one register operand against the forwarding sources; the lowest
// index (youngest) matching source wins, and register 0 never forwards.
module bypass_select #(
  parameter int XLEN       = 32,
  parameter int NUM_BYPASS = 2
) (
  input  logic [4:0]                 addr_i,
  input  logic [XLEN-1:0]            rf_data_i,
  input  logic [NUM_BYPASS-1:0]      byp_valid_i,
  input  logic [NUM_BYPASS-1:0]      byp_pending_i,
  input  logic [5*NUM_BYPASS-1:0]    byp_rd_i,
  input  logic [XLEN*NUM_BYPASS-1:0] byp_data_i,
  output logic [XLEN-1:0]            data_o,
  output logic                       hit_pending_o
);

  // Walk oldest to youngest so the youngest match is the last one written.
  always_comb begin
    data_o        = rf_data_i;
    hit_pending_o = 1'b0;
    if (addr_i != 5'd0) begin
      for (int i = NUM_BYPASS - 1; i >= 0; i--) begin
        if (byp_valid_i[i] && (byp_rd_i[5*i +: 5] == addr_i)) begin
          data_o        = byp_data_i[XLEN*i +: XLEN];
          hit_pending_o = byp_pending_i[i];
        end
      end
    end
  end

endmodule

// File: rtl/alu_src_stage.sv
// ALU operand stage: source muxes, optional forwarding (ALU_SRC_BYPASS_EN),
// load-use stall and the ID/EX register behind a valid/ready handshake.
module alu_src_stage
  import alu_src_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NUM_BYPASS = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [XLEN-1:0]            pc_i,
  input  logic [XLEN-1:0]            rs1_data_i,
  input  logic [XLEN-1:0]            rs2_data_i,
  input  logic [XLEN-1:0]            imm_i,
  input  logic [4:0]                 rs1_addr_i,
  input  logic [4:0]                 rs2_addr_i,
  input  logic [SEL_SRC_A_WIDTH-1:0] sel_a_i,
  input  logic [SEL_SRC_B_WIDTH-1:0] sel_b_i,
  input  logic [NUM_BYPASS-1:0]      byp_valid_i,
  input  logic [NUM_BYPASS-1:0]      byp_pending_i,
  input  logic [5*NUM_BYPASS-1:0]    byp_rd_i,
  input  logic [XLEN*NUM_BYPASS-1:0] byp_data_i,
  input  logic                       flush_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [XLEN-1:0]            alu_src_a_o,
  output logic [XLEN-1:0]            alu_src_b_o,
  output logic [XLEN-1:0]            store_data_o
);

  logic [XLEN-1:0] rs1_fwd, rs2_fwd;
  logic            hazard;
  logic [XLEN-1:0] src_a_d, src_b_d;
  logic [XLEN-1:0] src_a_q, src_b_q, store_q;
  logic            valid_d, valid_q;
  logic            capture;

`ifdef ALU_SRC_BYPASS_EN
  logic rs1_pend, rs2_pend;

  bypass_select #(.XLEN(XLEN), .NUM_BYPASS(NUM_BYPASS)) u_byp_rs1 (
    .addr_i        (rs1_addr_i),
    .rf_data_i     (rs1_data_i),
    .byp_valid_i   (byp_valid_i),
    .byp_pending_i (byp_pending_i),
    .byp_rd_i      (byp_rd_i),
    .byp_data_i    (byp_data_i),
    .data_o        (rs1_fwd),
    .hit_pending_o (rs1_pend)
  );

  bypass_select #(.XLEN(XLEN), .NUM_BYPASS(NUM_BYPASS)) u_byp_rs2 (
    .addr_i        (rs2_addr_i),
    .rf_data_i     (rs2_data_i),
    .byp_valid_i   (byp_valid_i),
    .byp_pending_i (byp_pending_i),
    .byp_rd_i      (byp_rd_i),
    .byp_data_i    (byp_data_i),
    .data_o        (rs2_fwd),
    .hit_pending_o (rs2_pend)
  );

  // rs2 always matters because store_data consumes it regardless of sel_b.
  assign hazard = (rs1_pend && (sel_a_i == SEL_A_RS1)) || rs2_pend;
`else
  logic byp_unused;

  assign rs1_fwd    = rs1_data_i;
  assign rs2_fwd    = rs2_data_i;
  assign hazard     = 1'b0;
  assign byp_unused = ^{rs1_addr_i, rs2_addr_i, byp_valid_i, byp_pending_i,
                        byp_rd_i, byp_data_i};
`endif

  always_comb begin
    src_a_d = '0;
    case (sel_a_e'(sel_a_i))
      SEL_A_RS1: src_a_d = rs1_fwd;
      SEL_A_PC:  src_a_d = pc_i;
      SEL_A_IMM: src_a_d = imm_i;
      default:   src_a_d = '0;
    endcase
  end

  always_comb begin
    src_b_d = '0;
    case (sel_b_e'(sel_b_i))
      SEL_B_RS2:    src_b_d = rs2_fwd;
      SEL_B_IMM:    src_b_d = imm_i;
      SEL_B_CONST4: src_b_d = {{(XLEN-3){1'b0}}, CONST4};
      default:      src_b_d = '0;
    endcase
  end

  assign in_ready_o = (!valid_q || out_ready_i) && !hazard;
  assign capture    = in_valid_i && in_ready_o;

  // Flush beats capture and drain; a held beat with no new capture drains.
  always_comb begin
    valid_d = valid_q;
    if (flush_i)                      valid_d = 1'b0;
    else if (capture)                 valid_d = 1'b1;
    else if (valid_q && out_ready_i)  valid_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      src_a_q <= '0;
      src_b_q <= '0;
      store_q <= '0;
    end else begin
      valid_q <= valid_d;
      if (capture && !flush_i) begin
        src_a_q <= src_a_d;
        src_b_q <= src_b_d;
        store_q <= rs2_fwd;
      end
    end
  end

  assign out_valid_o  = valid_q;
  assign alu_src_a_o  = src_a_q;
  assign alu_src_b_o  = src_b_q;
  assign store_data_o = store_q;

endmodule

// File: tb/tb_alu_src_stage.sv
// Scoreboard bench for alu_src_stage; its model follows ALU_SRC_BYPASS_EN.
module tb_alu_src_stage;
  import alu_src_pkg::*;

  localparam int XLEN = 32;
  localparam int NB   = 2;
`ifdef ALU_SRC_BYPASS_EN
  localparam bit BYP_EN = 1'b1;
`else
  localparam bit BYP_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rstN, inValid, inReady, flush, outValid, outReady;
  logic [XLEN-1:0] pc, rs1Data, rs2Data, imm;
  logic [4:0]      rs1Addr, rs2Addr;
  logic [1:0]      selA, selB;
  logic [NB-1:0]   bypValid, bypPending;
  logic [5*NB-1:0] bypRd;
  logic [XLEN*NB-1:0] bypData;
  logic [XLEN-1:0] aluSrcA, aluSrcB, storeData;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] st;
  } exp_t;

  exp_t expQ[$];
  int   checkCount = 0;
  int   errorCount = 0;

  always #5 clk = ~clk;

  alu_src_stage #(.XLEN(XLEN), .NUM_BYPASS(NB)) dut (
    .clk_i         (clk),
    .rst_ni        (rstN),
    .in_valid_i    (inValid),
    .in_ready_o    (inReady),
    .pc_i          (pc),
    .rs1_data_i    (rs1Data),
    .rs2_data_i    (rs2Data),
    .imm_i         (imm),
    .rs1_addr_i    (rs1Addr),
    .rs2_addr_i    (rs2Addr),
    .sel_a_i       (selA),
    .sel_b_i       (selB),
    .byp_valid_i   (bypValid),
    .byp_pending_i (bypPending),
    .byp_rd_i      (bypRd),
    .byp_data_i    (bypData),
    .flush_i       (flush),
    .out_valid_o   (outValid),
    .out_ready_i   (outReady),
    .alu_src_a_o   (aluSrcA),
    .alu_src_b_o   (aluSrcB),
    .store_data_o  (storeData)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)",
               tag, observed, expected, $time);
    end
  endtask

  // First matching source in index order wins; register 0 never forwards.
  function automatic logic [XLEN-1:0] modelFwd(input logic [4:0] addr,
                                               input logic [XLEN-1:0] rf,
                                               output logic pend);
    logic [XLEN-1:0] val;
    logic            found;
    val   = rf;
    pend  = 1'b0;
    found = 1'b0;
    if (BYP_EN && addr != 5'd0) begin
      for (int i = 0; i < NB; i++) begin
        if (!found && bypValid[i] && bypRd[5*i +: 5] == addr) begin
          val   = bypData[XLEN*i +: XLEN];
          pend  = bypPending[i];
          found = 1'b1;
        end
      end
    end
    return val;
  endfunction

  // Checks the current cycle against the model, then advances one clock.
  task automatic applyStimulus();
    logic            p1, p2, hz, expReady;
    logic [XLEN-1:0] r1, r2;
    logic [XLEN-1:0] candA[4];
    logic [XLEN-1:0] candB[4];
    exp_t            e;
    @(negedge clk);
    if (rstN) begin
      r1 = modelFwd(rs1Addr, rs1Data, p1);
      r2 = modelFwd(rs2Addr, rs2Data, p2);
      hz = (p1 && selA == 2'd0) || p2;
      expReady = ((expQ.size() == 0) || outReady) && !hz;
      checkOutput("in_ready", 64'(inReady), 64'(expReady));
      checkOutput("out_valid", 64'(outValid), 64'(expQ.size() != 0));
      if (expQ.size() != 0) begin
        checkOutput("alu_src_a", 64'(aluSrcA), 64'(expQ[0].a));
        checkOutput("alu_src_b", 64'(aluSrcB), 64'(expQ[0].b));
        checkOutput("store_data", 64'(storeData), 64'(expQ[0].st));
        if (outReady) void'(expQ.pop_front());
      end
      if (inValid && expReady) begin
        candA = '{r1, pc, imm, 32'h0};
        candB = '{r2, imm, 32'h4, 32'h0};
        e.a  = candA[selA];
        e.b  = candB[selB];
        e.st = r2;
        expQ.push_back(e);
      end
      if (flush) expQ.delete();
    end else begin
      expQ.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic setBypass(input logic [NB-1:0] v, input logic [NB-1:0] p,
                           input logic [4:0] rd0, input logic [4:0] rd1,
                           input logic [XLEN-1:0] d0, input logic [XLEN-1:0] d1);
    bypValid   = v;
    bypPending = p;
    bypRd      = {rd1, rd0};
    bypData    = {d1, d0};
  endtask

  initial begin
    rstN = 1'b0; inValid = 1'b0; flush = 1'b0; outReady = 1'b1;
    pc = 32'h20; rs1Data = 32'hA; rs2Data = 32'h5; imm = 32'h4;
    rs1Addr = 5'd1; rs2Addr = 5'd2; selA = 2'd0; selB = 2'd0;
    setBypass('0, '0, 5'd0, 5'd0, '0, '0);
    applyStimulus();
    applyStimulus();
    checkOutput("rst_valid", 64'(outValid), 64'h0);
    checkOutput("rst_a", 64'(aluSrcA), 64'h0);
    checkOutput("rst_b", 64'(aluSrcB), 64'h0);
    checkOutput("rst_store", 64'(storeData), 64'h0);
    rstN = 1'b1;

    // Mux sweep, back-to-back.
    for (int s = 0; s < 4; s++) begin
      selA = 2'(s); selB = 2'(s); inValid = 1'b1;
      applyStimulus();
    end
    inValid = 1'b0;
    applyStimulus();

    // Forwarding priority, then register 0.
    setBypass(2'b11, 2'b00, 5'd3, 5'd3, 32'h222, 32'h111);
    rs1Addr = 5'd3; selA = 2'd0; selB = 2'd0; inValid = 1'b1;
    applyStimulus();
    rs1Addr = 5'd0;
    applyStimulus();
    inValid = 1'b0;
    applyStimulus();

    // Load-use on rs2 for three cycles, then release with new data.
    rs1Addr = 5'd1; rs2Addr = 5'd5; inValid = 1'b1;
    setBypass(2'b01, 2'b01, 5'd5, 5'd0, 32'hDEAD, 32'h0);
    repeat (3) applyStimulus();
    setBypass(2'b01, 2'b00, 5'd5, 5'd0, 32'h333, 32'h0);
    applyStimulus();
    setBypass('0, '0, 5'd0, 5'd0, '0, '0);

    // Backpressure for four cycles, then drain and capture together.
    outReady = 1'b0; rs1Data = 32'h77; selA = 2'd0; selB = 2'd2;
    repeat (4) applyStimulus();
    outReady = 1'b1; rs1Data = 32'h88;
    applyStimulus();

    // Flush while holding a beat and offering another.
    outReady = 1'b0; rs1Data = 32'h99;
    applyStimulus();
    flush = 1'b1;
    applyStimulus();
    flush = 1'b0; inValid = 1'b0;
    checkOutput("flush_valid", 64'(outValid), 64'h0);
    applyStimulus();

    // Reset mid-stream while a beat is held.
    inValid = 1'b1; rs1Data = 32'h1234;
    applyStimulus();
    rstN = 1'b0;
    applyStimulus();
    checkOutput("mid_rst_valid", 64'(outValid), 64'h0);
    checkOutput("mid_rst_a", 64'(aluSrcA), 64'h0);
    checkOutput("mid_rst_store", 64'(storeData), 64'h0);
    rstN = 1'b1; outReady = 1'b1;

    // Random traffic.
    for (int n = 0; n < 60; n++) begin
      logic [4:0] addrs[3];
      addrs    = '{5'd0, 5'd3, 5'd5};
      inValid  = 1'($urandom_range(0, 1));
      outReady = ($urandom_range(0, 3) != 0);
      selA     = 2'($urandom_range(0, 3));
      selB     = 2'($urandom_range(0, 3));
      rs1Addr  = addrs[$urandom_range(0, 2)];
      rs2Addr  = addrs[$urandom_range(0, 2)];
      rs1Data  = $urandom; rs2Data = $urandom; pc = $urandom; imm = $urandom;
      setBypass(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                addrs[$urandom_range(0, 2)], addrs[$urandom_range(0, 2)],
                $urandom, $urandom);
      applyStimulus();
    end
    inValid = 1'b0; outReady = 1'b1;
    repeat (3) applyStimulus();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
